// File: rtl/wb_tlul_host_bridge.sv
// Wishbone classic slave to TL-UL host bridge: one A request per Wishbone cycle, single-cycle ack.
// Optional D-channel timeout with late-response draining when WB_TLUL_TIMEOUT_EN is defined.
module wb_tlul_host_bridge #(
  parameter int unsigned         SRC_W          = 8,
  parameter logic [SRC_W-1:0]    SOURCE_ID      = '0,
  parameter logic [31:0]         ERR_DATA       = 32'hDEAD_BEEF,
  parameter int unsigned         TIMEOUT_CYCLES = 1024
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [3:0]       wbs_sel_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic             tl_a_valid_o,
  input  logic             tl_a_ready_i,
  output logic [2:0]       tl_a_opcode_o,
  output logic [1:0]       tl_a_size_o,
  output logic [3:0]       tl_a_mask_o,
  output logic [31:0]      tl_a_address_o,
  output logic [31:0]      tl_a_data_o,
  output logic [SRC_W-1:0] tl_a_source_o,
  input  logic             tl_d_valid_i,
  output logic             tl_d_ready_o,
  input  logic [2:0]       tl_d_opcode_i,
  input  logic [31:0]      tl_d_data_i,
  input  logic             tl_d_error_i,
  output logic             bus_err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP, ST_ACK} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, data_q, data_d, rdata_q, rdata_d;
  logic [3:0]  mask_q, mask_d;
  logic [2:0]  op_q, op_d;
  logic        we_q, we_d, err_q, err_d;

  logic unused_inputs;
  assign unused_inputs = ^{tl_d_opcode_i, wbs_adr_i[1:0]};

`ifdef WB_TLUL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain_q, drain_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    op_d    = op_q;
    we_d    = we_q;
    err_d   = err_q;
    rdata_d = rdata_q;
`ifdef WB_TLUL_TIMEOUT_EN
    cnt_d   = cnt_q;
    drain_d = drain_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          addr_d  = {wbs_adr_i[31:2], 2'b00};
          data_d  = wbs_dat_i;
          we_d    = wbs_we_i;
          mask_d  = wbs_we_i ? wbs_sel_i : 4'hF;
          op_d    = !wbs_we_i ? 3'd4 : ((wbs_sel_i == 4'hF) ? 3'd0 : 3'd1);
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (tl_a_ready_i) begin
          state_d = ST_RESP;
`ifdef WB_TLUL_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_RESP: begin
`ifdef WB_TLUL_TIMEOUT_EN
        // A pending drain means the first response seen belongs to the timed-out access.
        if (tl_d_valid_i && drain_q) begin
          drain_d = 1'b0;
        end else if (tl_d_valid_i) begin
          err_d   = tl_d_error_i;
          if (!we_q) rdata_d = tl_d_error_i ? ERR_DATA : tl_d_data_i;
          state_d = ST_ACK;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          if (!we_q) rdata_d = ERR_DATA;
          drain_d = 1'b1;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        if (tl_d_valid_i) begin
          err_d   = tl_d_error_i;
          if (!we_q) rdata_d = tl_d_error_i ? ERR_DATA : tl_d_data_i;
          state_d = ST_ACK;
        end
`endif
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef WB_TLUL_TIMEOUT_EN
    if (state_q != ST_RESP && tl_d_valid_i) drain_d = 1'b0;
`endif
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      op_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef WB_TLUL_TIMEOUT_EN
      cnt_q   <= '0;
      drain_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      op_q    <= op_d;
      we_q    <= we_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef WB_TLUL_TIMEOUT_EN
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
`endif
    end
  end

  assign wbs_ack_o      = (state_q == ST_ACK);
  assign bus_err_o      = (state_q == ST_ACK) && err_q;
  assign wbs_dat_o      = rdata_q;
  assign tl_a_valid_o   = (state_q == ST_REQ);
  assign tl_a_opcode_o  = op_q;
  assign tl_a_size_o    = 2'd2;
  assign tl_a_mask_o    = mask_q;
  assign tl_a_address_o = addr_q;
  assign tl_a_data_o    = data_q;
  assign tl_a_source_o  = SOURCE_ID;
`ifdef WB_TLUL_TIMEOUT_EN
  assign tl_d_ready_o   = (state_q == ST_RESP) || drain_q;
`else
  assign tl_d_ready_o   = (state_q == ST_RESP);
`endif

endmodule

// File: tb/tb_wb_tlul_host_bridge.sv
// Self-checking bench for wb_tlul_host_bridge: directed vector table, random transactions
// against a transaction-level model, reset-mid-response and timeout/no-timeout sequences.
module tb_wb_tlul_host_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, wdat = '0;
  logic [3:0]  sel = '0;
  logic        ack, bus_err;
  logic [31:0] rdat;
  logic        a_valid, a_ready = 1'b0;
  logic [2:0]  a_op;
  logic [1:0]  a_size;
  logic [3:0]  a_mask;
  logic [31:0] a_addr, a_data;
  logic [7:0]  a_src;
  logic        d_valid = 1'b0, d_ready, d_err = 1'b0;
  logic [2:0]  d_op = '0;
  logic [31:0] d_data = '0;

  wb_tlul_host_bridge #(.SRC_W(8), .SOURCE_ID(8'h00), .ERR_DATA(32'hDEAD_BEEF), .TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
    .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .tl_a_valid_o(a_valid), .tl_a_ready_i(a_ready), .tl_a_opcode_o(a_op), .tl_a_size_o(a_size),
    .tl_a_mask_o(a_mask), .tl_a_address_o(a_addr), .tl_a_data_o(a_data), .tl_a_source_o(a_src),
    .tl_d_valid_i(d_valid), .tl_d_ready_o(d_ready), .tl_d_opcode_i(d_op), .tl_d_data_i(d_data),
    .tl_d_error_i(d_err), .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0, n_err = 0;
  logic [31:0] model_dat = '0;

  typedef struct {
    logic        we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    int          a_wait, d_wait;
    logic        derr;
    logic [31:0] ddata;
    logic [2:0]  e_op;
    logic [3:0]  e_mask;
    logic [31:0] e_addr, e_rdata;
    logic        e_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_op(input logic w, input logic [3:0] s);
    if (!w) return 3'd4;
    return (s == 4'hF) ? 3'd0 : 3'd1;
  endfunction

  task automatic run_txn(input vec_t v);
    int a_cnt = 0, d_cnt = 0, acks = 0, reqs = 0, ack_cyc = -1;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = v.we; adr = v.adr; wdat = v.dat; sel = v.sel;
    for (int c = 1; c <= v.a_wait + v.d_wait + 8; c++) begin
      @(negedge clk);
      if (ack) begin
        acks++; ack_cyc = c;
        check("ack_rdata", rdat, v.e_rdata);
        check("ack_bus_err", {31'd0, bus_err}, {31'd0, v.e_err});
        cyc = 1'b0; stb = 1'b0;
      end else begin
        check("bus_err_idle", {31'd0, bus_err}, 32'd0);
      end
      if (a_valid) begin
        check("a_opcode", {29'd0, a_op}, {29'd0, v.e_op});
        check("a_mask", {28'd0, a_mask}, {28'd0, v.e_mask});
        check("a_address", a_addr, v.e_addr);
        check("a_data", a_data, v.dat);
        check("a_size", {30'd0, a_size}, 32'd2);
        check("a_source", {24'd0, a_src}, 32'd0);
        if (a_cnt < v.a_wait) begin a_ready = 1'b0; a_cnt++; end
        else begin a_ready = 1'b1; reqs++; end
      end else begin
        a_ready = 1'b0;
      end
      if (d_ready && d_cnt >= v.d_wait) begin
        d_valid = 1'b1; d_data = v.ddata; d_err = v.derr;
      end else begin
        if (d_ready) d_cnt++;
        d_valid = 1'b0; d_data = $urandom; d_err = 1'($urandom);
      end
    end
    d_valid = 1'b0; a_ready = 1'b0;
    check("ack_count", 32'(acks), 32'd1);
    check("ack_cycle", 32'(ack_cyc), 32'(3 + v.a_wait + v.d_wait));
    check("a_req_count", 32'(reqs), 32'd1);
    check("rdata_hold", rdat, v.e_rdata);
    model_dat = v.e_rdata;
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 32'h3000_0004, 32'h0, 4'h0, 0, 0, 1'b0, 32'h1234_5678, 3'd4, 4'hF, 32'h3000_0004, 32'h1234_5678, 1'b0};
    tbl[1] = '{1'b1, 32'h3000_0010, 32'hA5A5_0001, 4'hF, 0, 0, 1'b0, 32'h5555_5555, 3'd0, 4'hF, 32'h3000_0010, 32'h1234_5678, 1'b0};
    tbl[2] = '{1'b1, 32'h3000_0007, 32'h0BEE_F00D, 4'h6, 1, 2, 1'b0, 32'h6666_6666, 3'd1, 4'h6, 32'h3000_0004, 32'h1234_5678, 1'b0};
    tbl[3] = '{1'b0, 32'h3000_0102, 32'h0, 4'h3, 5, 3, 1'b0, 32'h0BAD_F00D, 3'd4, 4'hF, 32'h3000_0100, 32'h0BAD_F00D, 1'b0};
    tbl[4] = '{1'b0, 32'h3000_0008, 32'h0, 4'hF, 0, 1, 1'b1, 32'h7777_7777, 3'd4, 4'hF, 32'h3000_0008, 32'hDEAD_BEEF, 1'b1};
    tbl[5] = '{1'b1, 32'h3000_000C, 32'h0000_00AA, 4'h1, 2, 0, 1'b1, 32'h8888_8888, 3'd1, 4'h1, 32'h3000_000C, 32'hDEAD_BEEF, 1'b1};

    #12;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_rdata", rdat, 32'd0);
    check("rst_a_valid", {31'd0, a_valid}, 32'd0);
    check("rst_d_ready", {31'd0, d_ready}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("rst_a_address", a_addr, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      rv.we = 1'($urandom); rv.adr = $urandom; rv.dat = $urandom; rv.sel = 4'($urandom);
      rv.a_wait = $urandom_range(0, 3); rv.d_wait = $urandom_range(0, 3);
      rv.derr = ($urandom_range(0, 3) == 0); rv.ddata = $urandom;
      rv.e_op = ref_op(rv.we, rv.sel);
      rv.e_mask = rv.we ? rv.sel : 4'hF;
      rv.e_addr = rv.adr & 32'hFFFF_FFFC;
      rv.e_rdata = rv.we ? model_dat : (rv.derr ? 32'hDEAD_BEEF : rv.ddata);
      rv.e_err = rv.derr;
      run_txn(rv);
    end

    // Reset while the response is outstanding.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0020; a_ready = 1'b1;
    for (int c = 0; c < 10 && !d_ready; c++) @(negedge clk);
    check("reached_resp", {31'd0, d_ready}, 32'd1);
    cyc = 1'b0; stb = 1'b0; a_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ack", {31'd0, ack}, 32'd0);
    check("mid_rst_rdata", rdat, 32'd0);
    check("mid_rst_a_valid", {31'd0, a_valid}, 32'd0);
    check("mid_rst_d_ready", {31'd0, d_ready}, 32'd0);
    check("mid_rst_bus_err", {31'd0, bus_err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    model_dat = '0;
    run_txn('{1'b0, 32'h3000_0030, 32'h0, 4'hF, 0, 0, 1'b0, 32'hCAFE_0001, 3'd4, 4'hF, 32'h3000_0030, 32'hCAFE_0001, 1'b0});

    // Response that never arrives.
    begin
      int got = 0, ack_cyc = -1;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0040; d_valid = 1'b0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        a_ready = a_valid;
        if (ack) begin
          got++; ack_cyc = c;
          check("to_rdata", rdat, 32'hDEAD_BEEF);
          check("to_bus_err", {31'd0, bus_err}, 32'd1);
          cyc = 1'b0; stb = 1'b0;
        end
      end
      a_ready = 1'b0;
`ifdef WB_TLUL_TIMEOUT_EN
      check("to_ack_count", 32'(got), 32'd1);
      check("to_ack_cycle", 32'(ack_cyc), 32'd18);
      model_dat = 32'hDEAD_BEEF;
      check("drain_d_ready", {31'd0, d_ready}, 32'd1);
      d_valid = 1'b1; d_data = 32'h1111_1111; d_err = 1'b0;
      @(negedge clk);
      d_valid = 1'b0;
      got = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (ack) got++;
      end
      check("late_resp_no_ack", 32'(got), 32'd0);
      check("late_resp_rdata", rdat, 32'hDEAD_BEEF);
      run_txn('{1'b0, 32'h3000_0050, 32'h0, 4'hF, 0, 0, 1'b0, 32'hCAFE_0002, 3'd4, 4'hF, 32'h3000_0050, 32'hCAFE_0002, 1'b0});
`else
      check("no_to_ack_count", 32'(got), 32'd0);
      check("no_to_d_ready", {31'd0, d_ready}, 32'd1);
      d_valid = 1'b1; d_data = 32'h2222_0000; d_err = 1'b0;
      @(negedge clk);
      d_valid = 1'b0;
      check("late_ack", {31'd0, ack}, 32'd1);
      check("late_rdata", rdat, 32'h2222_0000);
      check("late_bus_err", {31'd0, bus_err}, 32'd0);
      cyc = 1'b0; stb = 1'b0;
      model_dat = 32'h2222_0000;
      run_txn('{1'b1, 32'h3000_0060, 32'h0102_0304, 4'hC, 1, 1, 1'b0, 32'h0, 3'd1, 4'hC, 32'h3000_0060, 32'h2222_0000, 1'b0});
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
